// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel-pipeline alignment
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIX_LATENCY = 2,
    parameter int   CW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          req,
    output logic          frame_start,
    output logic          line_start,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic [7:0]    VGAR,
    output logic [7:0]    VGAG,
    output logic [7:0]    VGAB
);

    // Region boundaries expressed at counter width so every compare is width-matched.
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    localparam int LAST = PIX_LATENCY - 1;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;

    logic h_active;
    logic v_active;
    logic h_sync_region;
    logic v_sync_region;
    logic at_line_start;
    logic at_frame_start;

    // Stage-0 sync flags are kept in "asserted" sense; polarity is applied only at the pins.
    logic hs0;
    logic vs0;

    logic [PIX_LATENCY-1:0] hs_dly;
    logic [PIX_LATENCY-1:0] vs_dly;
    logic [PIX_LATENCY-1:0] req_dly;

    logic hs_tail;
    logic vs_tail;
    logic req_tail;

    // Next raster position: h wraps every line, v wraps on the last pixel of the last line.
    always_comb begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            if (v_cnt == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = v_cnt + 1'b1;
            end
        end
    end

    // Region decode of the current counter position; the FSM is implicit in these ranges.
    always_comb begin
        h_active       = (h_cnt < H_ACT_END);
        v_active       = (v_cnt < V_ACT_END);
        h_sync_region  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_region  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        at_line_start  = (h_cnt == '0);
        at_frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // Free-running horizontal and vertical counters, advancing once per pixel enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Stage 0: coordinate, request and pulse outputs registered straight from the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x           <= '0;
            y           <= '0;
            req         <= 1'b0;
            hs0         <= 1'b0;
            vs0         <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            x           <= h_cnt;
            y           <= v_cnt;
            req         <= h_active && v_active;
            hs0         <= h_sync_region;
            vs0         <= v_sync_region;
            frame_start <= at_frame_start;
            line_start  <= at_line_start;
        end
    end

    // Delay line matching the pixel source latency; reset loads idle sync and blank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_dly  <= '0;
            vs_dly  <= '0;
            req_dly <= '0;
        end else if (en) begin
            hs_dly[0]  <= hs0;
            vs_dly[0]  <= vs0;
            req_dly[0] <= req;
            for (int i = 1; i < PIX_LATENCY; i++) begin
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
                req_dly[i] <= req_dly[i-1];
            end
        end
    end

    // Tail taps of the delay line feed the pin register.
    always_comb begin
        hs_tail  = hs_dly[LAST];
        vs_tail  = vs_dly[LAST];
        req_tail = req_dly[LAST];
    end

    // Pin register: apply sync polarity and gate RGB so pixel data outside active video is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
            VGAR        <= 8'd0;
            VGAG        <= 8'd0;
            VGAB        <= 8'd0;
        end else if (en) begin
            VGA_HS      <= hs_tail ? HS_POL : ~HS_POL;
            VGA_VS      <= vs_tail ? VS_POL : ~VS_POL;
            VGA_BLANK_N <= req_tail;
            VGAR        <= req_tail ? pix_r : 8'd0;
            VGAG        <= req_tail ? pix_g : 8'd0;
            VGAB        <= req_tail ? pix_b : 8'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against a raster-position model
module tb_vga_timing_gen;

    localparam int HA = 20, HF = 3, HSW = 4, HB = 5;
    localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;
    localparam int L = 3;
    localparam int CW = 11;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          req;
        logic          fs;
        logic          ls;
        logic          hs;
        logic          vs;
        logic          bn;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [7:0] pix_r, pix_g, pix_b;
    logic [CW-1:0] x, y;
    logic req, frame_start, line_start, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGAR, VGAG, VGAB;

    int checks = 0;
    int passes = 0;
    int k = 0;
    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LATENCY(L), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x), .y(y), .req(req), .frame_start(frame_start), .line_start(line_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGAR(VGAR), .VGAG(VGAG), .VGAB(VGAB)
    );

    // Model pixel source: returns (x, y, x+y) L enabled cycles after the coordinate was presented.
    logic [7:0] sr [L];
    logic [7:0] sg [L];
    logic [7:0] sbl [L];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                sr[i] <= 8'd0; sg[i] <= 8'd0; sbl[i] <= 8'd0;
            end
        end else if (en) begin
            sr[0]  <= x[7:0];
            sg[0]  <= y[7:0];
            sbl[0] <= x[7:0] + y[7:0];
            for (int i = 1; i < L; i++) begin
                sr[i] <= sr[i-1]; sg[i] <= sg[i-1]; sbl[i] <= sbl[i-1];
            end
        end
    end
    assign pix_r = sr[L-1];
    assign pix_g = sg[L-1];
    assign pix_b = sbl[L-1];

    // Expected outputs after n enabled cycles since reset, from raster position arithmetic.
    function automatic exp_t model(input int n);
        exp_t e;
        int p, h, v;
        bit act;
        e = '0;
        e.hs = ~HS_POL;
        e.vs = ~VS_POL;
        if (n >= 1) begin
            p = n - 1;
            h = p % HT;
            v = (p / HT) % VT;
            e.x = CW'(h);
            e.y = CW'(v);
            e.req = (h < HA) && (v < VA);
            e.fs = (h == 0) && (v == 0);
            e.ls = (h == 0);
        end
        if (n >= L + 2) begin
            p = n - L - 2;
            h = p % HT;
            v = (p / HT) % VT;
            act = (h < HA) && (v < VA);
            e.hs = (h >= HA + HF && h < HA + HF + HSW) ? HS_POL : ~HS_POL;
            e.vs = (v >= VA + VF && v < VA + VF + VSW) ? VS_POL : ~VS_POL;
            e.bn = act;
            if (act) begin
                e.r = 8'(h % 256);
                e.g = 8'(v % 256);
                e.b = 8'((h + v) % 256);
            end
        end
        return e;
    endfunction

    function automatic exp_t dut_vec();
        return {x, y, req, frame_start, line_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGAR, VGAG, VGAB};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s t=%0t actual=%h required=%h (x=%0d/%0d y=%0d/%0d hs=%b/%b vs=%b/%b bn=%b/%b r=%0d/%0d)",
                      name, $time, got, want, got.x, want.x, got.y, want.y,
                      got.hs, want.hs, got.vs, want.vs, got.bn, want.bn, got.r, want.r);
    endtask

    // Monitor: each enabled edge presents a new output set; between them the outputs must hold.
    initial cur = model(0);
    always @(posedge clk) begin
        automatic bit fire = en && rst;
        #1;
        if (!rst) begin
            cur = model(0);
        end else if (fire) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_underflow t=%0t actual=empty required=entry", $time);
            end else begin
                cur = sb.pop_front();
            end
        end
        check("scoreboard", dut_vec(), cur);
    end

    task automatic step(input bit e);
        @(negedge clk);
        en = e;
        if (e) begin
            k++;
            sb.push_back(model(k));
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec(), model(0));
        rst = 1'b1;

        // Continuous enable across more than two frames.
        repeat (1400) step(1'b1);
        // Random enable pattern.
        repeat (1500) step(1'(($urandom & 1)));

        // Asynchronous reset mid-frame, held for three clocks.
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        #1 check("async_reset", dut_vec(), model(0));
        repeat (3) @(negedge clk);
        check("reset_hold", dut_vec(), model(0));
        rst = 1'b1;
        k = 0;

        // Mostly-enabled random pattern after reset release.
        repeat (1500) step(($urandom_range(0, 3) != 0));
        step(1'b0);
        step(1'b0);

        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with a pixel-pipeline alignment stage. It is the next generation of the team's fixed 640x480 controller.
- Generates HS/VS/blank from free-running horizontal and vertical counters. Timing, sync polarity and counter width are set by parameters.
- Exports the current pixel coordinate and a request strobe to an upstream pixel source. It then delays sync and blank so they line up with that source's RGB return.
- Sits between the pixel source (framebuffer/renderer) and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS
- PIX_LATENCY, 2, en-cycles from req/x/y to valid pix_r/g/b; range 1..8
- CW, 11, width of the counters and of x/y

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  pixel-clock enable; all state advances only when en=1
- pix_r  in  8  red from the pixel source, valid PIX_LATENCY en-cycles after req
- pix_g  in  8  green, same timing as pix_r
- pix_b  in  8  blue, same timing as pix_r
- x  out  CW  current horizontal count (0..H_TOTAL-1)
- y  out  CW  current vertical count (0..V_TOTAL-1)
- req  out  1  high when (x,y) is inside the active region
- frame_start  out  1  one en-cycle pulse at x=0, y=0
- line_start  out  1  one en-cycle pulse at x=0 on every line
- VGA_HS  out  1  horizontal sync, delayed by PIX_LATENCY
- VGA_VS  out  1  vertical sync, delayed by PIX_LATENCY
- VGA_BLANK_N  out  1  high during delayed active video
- VGAR  out  8  red to DAC
- VGAG  out  8  green to DAC
- VGAB  out  8  blue to DAC

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525). Both must fit in CW bits.
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst=0, asynchronous):
  - h_cnt, v_cnt, x, y = 0.
  - req, frame_start, line_start = 0.
  - VGA_HS = ~HS_POL; VGA_VS = ~VS_POL.
  - VGA_BLANK_N = 0; RGB = 0.
  - Every delay-line stage is loaded with the inactive sync levels and blank.
- Counters (only when en=1):
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt and v_cnt are both at their terminal values.
  - The state machine is implicit in the counter ranges. Horizontal regions are ACTIVE [0,H_ACTIVE), FRONT, SYNC, BACK. Vertical regions use the same scheme in lines.
- Stage 0 (registered from the counters):
  - x = h_cnt, y = v_cnt.
  - req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 is asserted when h_cnt is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vs0 is asserted when v_cnt is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC). VS edges therefore coincide with the h_cnt=0 boundary.
  - frame_start = (h_cnt==0 && v_cnt==0); line_start = (h_cnt==0).
- Delay line:
  - hs0, vs0 and req pass through a PIX_LATENCY-deep shift register that advances only on en.
  - At the tail: VGA_HS = hs_d ? HS_POL : ~HS_POL, and VGA_VS likewise.
  - VGA_BLANK_N = req_d.
  - RGB is sampled in the same cycle as the tail: pix_* when req_d=1, else 0. Pixel inputs are ignored outside the active region.
- en=0: every register holds its value, including the pulses. A pulse therefore spans exactly one en=1 cycle, not one clk.
- Reset mid-frame: takes effect immediately. After release, the first en cycle begins at h=0, v=0. frame_start asserts after the first en cycle, and the delayed outputs stay inactive for PIX_LATENCY en cycles.
- Counter overflow is impossible by the parameter constraint. No saturation logic.

Test Plan:
- Defaults, en=1 constantly:
  - VGA_HS is low for exactly 96 clocks, falling 656+PIX_LATENCY+1 clocks after the first frame_start edge.
  - HS period is 800 clocks.
- Defaults:
  - VGA_VS is low for exactly 1600 clocks (2 lines).
  - The VS period is 420000 clocks.
  - The VS falling edge aligns with the HS-period boundary for line 490.
- Drive pix_r = x[7:0] with a 2-cycle model source:
  - On every cycle with VGA_BLANK_N=1, VGAR equals the pixel column index mod 256.
  - VGAR=0 on every cycle with VGA_BLANK_N=0.
  - There are exactly 640 blank-high cycles per visible line and 480 such lines per frame.
- en toggling 1,0,1,0: all periods double (HS period 1600 clk). frame_start stays high for 2 clk per frame, spanning 1 en cycle.
- Assert rst at y=200, x=300 for 3 clocks:
  - Outputs go to reset values immediately.
  - After release, x/y restart from 0,0 and frame_start pulses once.
  - No HS pulse appears for 656 en cycles.
- Override to H 800/40/128/88, V 600/1/4/23, HS_POL=1, VS_POL=1, CW=11:
  - HS is high for 128 clocks per 1056-clock line.
  - VS is high for 4 lines per 628-line frame.
  - 800x600 active pixels per frame.
